// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential signed divider.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div32_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div32_step #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted partial remainder can exceed WIDTH bits, so compare with one extra bit.
  always_comb begin
    shifted = {a_in, q_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, d_in});
    a_out   = fits ? (shifted[WIDTH-1:0] - d_in) : shifted[WIDTH-1:0];
    q_out   = {q_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock.
// Optional fast divide-by-zero path and div_zero flag when DIV32_DZ_FAST_EN is defined.
module div32_seq #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result
`ifdef DIV32_DZ_FAST_EN
  ,
  output logic               div_zero
`endif
);

  import div_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

`ifdef DIV32_DZ_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_reg, q_reg, d_reg, dvd_reg;
  logic               neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0]   quotient_reg, remainder_reg;
  logic [WIDTH-1:0]   a_step, q_step;
  logic               dz_in;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;

  assign dz_in   = (divisor == '0);
  // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps onto itself.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  div32_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_reg),
    .q_in  (q_reg),
    .d_in  (d_reg),
    .a_out (a_step),
    .q_out (q_step)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (FAST_DZ && dz_in) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN) || (state_reg == FIX);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_reg       <= '0;
      a_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      dvd_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            q_reg     <= dvd_mag;
            d_reg     <= dvs_mag;
            dvd_reg   <= dividend;
            neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_reg <= dividend[WIDTH-1];
            dz_reg    <= dz_in;
            if (FAST_DZ && dz_in) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend;
            end
          end
        end
        RUN: begin
          a_reg   <= a_step;
          q_reg   <= q_step;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        FIX: begin
          if (dz_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= dvd_reg;
          end else begin
            quotient_reg  <= neg_q_reg ? -q_reg : q_reg;
            remainder_reg <= neg_r_reg ? -a_reg : a_reg;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV32_DZ_FAST_EN
  logic div_zero_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      div_zero_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      div_zero_reg <= dz_in;
    end
  end

  assign div_zero = div_zero_reg;
`endif

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign result    = {remainder_reg, quotient_reg};

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: vector table, scoreboard queue, and multi-cycle corner sequences.
module tb_div32_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [63:0] result;
`ifdef DIV32_DZ_FAST_EN
  logic        div_zero;
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  div32_seq dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .result    (result)
`ifdef DIV32_DZ_FAST_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operation; a second start can be injected at RUN clock inject_at (-1 = none).
  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] q, input logic [31:0] r, input int inject_at);
    exp_t e;
    int   n;
    int   busy_cnt;
    int   idle_wait;
    bit   got;
    @(negedge clock);
    idle_wait = 0;
    while ((busy || done) && idle_wait < 60) begin
      @(negedge clock);
      idle_wait++;
    end
    if (idle_wait >= 60) check({tag, "_idle_timeout"}, 64'(idle_wait), 64'(0));
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.q   = q;
    e.r   = r;
    e.dz  = (dvs == 32'd0);
    e.lat = (FAST && dvs == 32'd0) ? 0 : 33;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n        = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (n <= 100) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (n == inject_at) start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
    end
    e = sb.pop_front();
    if (!got) begin
      check({tag, "_done_timeout"}, 64'(n), 64'(e.lat));
      return;
    end
    $display("[TB] %s: %0d / %0d -> q=0x%08h r=0x%08h after %0d clocks",
             tag, $signed(dvd), $signed(dvs), quotient, remainder, n);
    check({tag, "_latency"}, 64'(n), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
    check({tag, "_quotient"}, 64'(quotient), 64'(e.q));
    check({tag, "_remainder"}, 64'(remainder), 64'(e.r));
    check({tag, "_result"}, result, {e.r, e.q});
`ifdef DIV32_DZ_FAST_EN
    check({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
`endif
    @(posedge clock);
    #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_hold"}, {busy, done, result[61:0]}, {2'b00, e.r[29:0], e.q});
  endtask

  vec_t vecs[14];

  initial begin
    begin : watchdog
      fork
        begin
          #2_000_000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "watchdog");
        end
      join_none
    end

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFFFFF2,   32'd2};
    vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         32'hFFFFFFFE};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[5]  = '{32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF};
    vecs[6]  = '{32'd25,         32'd0,          32'hFFFFFFFF,   32'd25};
    vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[8]  = '{32'd7,          32'd100,        32'd0,          32'd7};
    vecs[9]  = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0};
    vecs[10] = '{32'h80000000,   32'd2,          32'hC0000000,   32'd0};
    vecs[11] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0};
    vecs[12] = '{-32'sd7,        32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9};
    vecs[13] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};

    clear    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {busy, done, result[61:0]}, 64'd0);
    clear = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, -1);
    end

    for (int i = 0; i < 4; i++) begin
      int a;
      int b;
      a = $urandom;
      b = $urandom_range(1, 100000);
      if (i[0]) b = -b;
      run_op($sformatf("rand%0d", i), a, b, a / b, a % b, -1);
    end

    // Second start during RUN must be ignored.
    run_op("second_start", 32'd100, 32'd7, 32'd14, 32'd2, 10);

    // Clear mid-RUN discards the operation.
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("clear_mid_run", {busy, done, result[61:0]}, 64'd0);
    check("clear_result", result, 64'd0);
    run_op("after_clear", 32'd9, 32'd3, 32'd3, 32'd0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
